// File: rtl/uart_loopback_ctrl.sv
// UART echo controller: pops received bytes, optionally folds case,
// and pushes them back to the transmitter with optional CR -> CR LF.
module uart_loopback_ctrl #(
  parameter int CASE_MODE   = 0,
  parameter int CRLF_EXPAND = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [7:0]             rx_data_in,
  input  logic                   rx_data_present,
  output logic                   read_rx_data_ack,
  output logic [7:0]             tx_data_out,
  output logic                   write_tx_data,
  input  logic                   tx_buffer_full,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] rx_count,
  output logic [COUNT_WIDTH-1:0] tx_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    SEND    = 2'd2,
    SEND_LF = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             tx_q, tx_d;
  logic                   ack_q, ack_d;
  logic                   wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] rxc_q, rxc_d;
  logic [COUNT_WIDTH-1:0] txc_q, txc_d;

  function automatic logic [7:0] fold(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (CASE_MODE == 1 && b >= 8'h61 && b <= 8'h7A)
      r = b - 8'h20;
    else if (CASE_MODE == 2 && b >= 8'h41 && b <= 8'h5A)
      r = b + 8'h20;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 8'h00;
      tx_q    <= 8'h00;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      rxc_q   <= '0;
      txc_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      rxc_q   <= rxc_d;
      txc_q   <= txc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (enable && rx_data_present)
          state_d = POP;
      POP:
        state_d = SEND;
      SEND:
        if (!tx_buffer_full) begin
          if (CRLF_EXPAND != 0 && hold_q == 8'h0D)
            state_d = SEND_LF;
          else
            state_d = IDLE;
        end
      SEND_LF:
        if (!tx_buffer_full)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    tx_d   = tx_q;
    ack_d  = 1'b0;
    wr_d   = 1'b0;
    rxc_d  = rxc_q;
    txc_d  = txc_q;
    busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE:
        if (enable && rx_data_present) begin
          hold_d = fold(rx_data_in);
          ack_d  = 1'b1;
          rxc_d  = rxc_q + ONE;
        end
      POP: ;
      SEND:
        if (!tx_buffer_full) begin
          tx_d  = hold_q;
          wr_d  = 1'b1;
          txc_d = txc_q + ONE;
        end
      SEND_LF:
        if (!tx_buffer_full) begin
          tx_d  = 8'h0A;
          wr_d  = 1'b1;
          txc_d = txc_q + ONE;
        end
      default: ;
    endcase
  end

  assign read_rx_data_ack = ack_q;
  assign write_tx_data    = wr_q;
  assign tx_data_out      = tx_q;
  assign busy             = busy_q;
  assign rx_count         = rxc_q;
  assign tx_count         = txc_q;

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Directed bench for uart_loopback_ctrl across case-fold and
// counter-width configurations sharing one stimulus stream.
module tb_uart_loopback_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] rx_data;
  logic       present;
  logic       full;

  logic        ack0, wr0, busy0;
  logic [7:0]  tx0;
  logic [15:0] rc0, tc0;
  logic        ack1, wr1, busy1;
  logic [7:0]  tx1;
  logic [15:0] rc1, tc1;
  logic        ack2, wr2, busy2;
  logic [7:0]  tx2;
  logic [15:0] rc2, tc2;
  logic        ack3, wr3, busy3;
  logic [7:0]  tx3;
  logic [3:0]  rc3, tc3;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  uart_loopback_ctrl #(.CASE_MODE(0), .CRLF_EXPAND(1), .COUNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data_in(rx_data), .rx_data_present(present),
    .read_rx_data_ack(ack0), .tx_data_out(tx0), .write_tx_data(wr0),
    .tx_buffer_full(full), .busy(busy0), .rx_count(rc0), .tx_count(tc0));

  uart_loopback_ctrl #(.CASE_MODE(1), .CRLF_EXPAND(1), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data_in(rx_data), .rx_data_present(present),
    .read_rx_data_ack(ack1), .tx_data_out(tx1), .write_tx_data(wr1),
    .tx_buffer_full(full), .busy(busy1), .rx_count(rc1), .tx_count(tc1));

  uart_loopback_ctrl #(.CASE_MODE(2), .CRLF_EXPAND(1), .COUNT_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data_in(rx_data), .rx_data_present(present),
    .read_rx_data_ack(ack2), .tx_data_out(tx2), .write_tx_data(wr2),
    .tx_buffer_full(full), .busy(busy2), .rx_count(rc2), .tx_count(tc2));

  uart_loopback_ctrl #(.CASE_MODE(0), .CRLF_EXPAND(1), .COUNT_WIDTH(4)) dut3 (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data_in(rx_data), .rx_data_present(present),
    .read_rx_data_ack(ack3), .tx_data_out(tx3), .write_tx_data(wr3),
    .tx_buffer_full(full), .busy(busy3), .rx_count(rc3), .tx_count(tc3));

  always @(negedge clk) begin
    if (ack0) acks <= acks + 1;
    if (wr0) q0.push_back(tx0);
    if (wr1) q1.push_back(tx1);
    if (wr2) q2.push_back(tx2);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    q2.delete();
    acks = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s ack timeout got=0 exp=1", nm);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    present = 1'b1;
    rx_data = b;
    wait_ack("send_ack", ok);
    present = 1'b0;
    for (int i = 0; i < 20 && busy0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    do_reset(2);
    total++;
    if ({ack0, wr0, busy0, tx0, rc0, tc0} !== 43'd0) begin
      bad++;
      $display("FAIL reset_init got=%h exp=0",
               {ack0, wr0, busy0, tx0, rc0, tc0});
    end
    full = 1'b1;
    present = 1'b1;
    rx_data = 8'h55;
    wait_ack("reset_ack", ok);
    present = 1'b0;
    tick(3);
    total++;
    if (busy0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_busy got=%b exp=1", busy0);
    end
    clear_logs();
    do_reset(3);
    total++;
    if ({ack0, wr0, busy0, tx0, rc0, tc0} !== 43'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0",
               {ack0, wr0, busy0, tx0, rc0, tc0});
    end
    full = 1'b0;
    tick(10);
    total++;
    if (q0.size() !== 0 || acks !== 0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_discard got=%0d/%0d exp=0/0",
               q0.size(), acks);
    end
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    clear_logs();
    present = 1'b1;
    rx_data = 8'h41;
    wait_ack("single_ack", ok);
    present = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (wr0) break;
    end
    total++;
    if (lat !== 2 || wr0 !== 1'b1) begin
      bad++;
      $display("FAIL single_lat got=%0d exp=2", lat);
    end
    total++;
    if (tx0 !== 8'h41) begin
      bad++;
      $display("FAIL single_data got=%h exp=41", tx0);
    end
    tick(5);
    total++;
    if (rc0 !== 16'd1 || tc0 !== 16'd1 || acks !== 1 || q0.size() !== 1) begin
      bad++;
      $display("FAIL single_cnt got=%0d/%0d/%0d exp=1/1/1",
               rc0, tc0, acks);
    end
  endtask

  task automatic test_crlf();
    bit ok;
    bit seen;
    clear_logs();
    present = 1'b1;
    rx_data = 8'h0D;
    wait_ack("cr_ack", ok);
    present = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr0) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || tx0 !== 8'h0D) begin
      bad++;
      $display("FAIL cr_first got=%h exp=0d", tx0);
    end
    @(negedge clk);
    total++;
    if (wr0 !== 1'b1 || tx0 !== 8'h0A) begin
      bad++;
      $display("FAIL cr_lf got=%b/%h exp=1/0a", wr0, tx0);
    end
    tick(5);
    total++;
    if (rc0 !== 16'd2 || tc0 !== 16'd3 || q0.size() !== 2) begin
      bad++;
      $display("FAIL cr_cnt got=%0d/%0d exp=2/3", rc0, tc0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    clear_logs();
    full = 1'b1;
    present = 1'b1;
    rx_data = 8'h62;
    wait_ack("bp_ack", ok);
    tick(50);
    total++;
    if (q0.size() !== 0 || busy0 !== 1'b1 || acks !== 1) begin
      bad++;
      $display("FAIL bp_hold got=%0d/%b/%0d exp=0/1/1",
               q0.size(), busy0, acks);
    end
    present = 1'b0;
    full = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr0) begin seen = 1'b1; break; end
    end
    tick(5);
    total++;
    if (!seen || q0.size() !== 1 || q0[0] !== 8'h62) begin
      bad++;
      $display("FAIL bp_release got=%0d exp=1 write of 62", q0.size());
    end
  endtask

  task automatic test_case_fold();
    logic [7:0] in_b[6]  = '{8'h61, 8'h5A, 8'h7B, 8'h41, 8'h5A, 8'h40};
    logic [7:0] up_b[6]  = '{8'h41, 8'h5A, 8'h7B, 8'h41, 8'h5A, 8'h40};
    logic [7:0] lo_b[6]  = '{8'h61, 8'h7A, 8'h7B, 8'h61, 8'h7A, 8'h40};
    clear_logs();
    for (int i = 0; i < 6; i++) send_byte(in_b[i]);
    tick(5);
    total++;
    if (q1.size() !== 6 || q2.size() !== 6) begin
      bad++;
      $display("FAIL fold_size got=%0d/%0d exp=6/6", q1.size(), q2.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q1[i] !== up_b[i]) begin
          bad++;
          $display("FAIL fold_up[%0d] got=%h exp=%h", i, q1[i], up_b[i]);
        end
        total++;
        if (q2[i] !== lo_b[i]) begin
          bad++;
          $display("FAIL fold_lo[%0d] got=%h exp=%h", i, q2[i], lo_b[i]);
        end
      end
    end
  endtask

  task automatic test_enable_wrap();
    do_reset(2);
    clear_logs();
    enable = 1'b0;
    present = 1'b1;
    rx_data = 8'h33;
    tick(10);
    total++;
    if (acks !== 0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL en_off got=%0d exp=0 acks", acks);
    end
    present = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 17; i++) send_byte(8'h30 + 8'(i));
    tick(5);
    total++;
    if (rc3 !== 4'd1 || tc3 !== 4'd1) begin
      bad++;
      $display("FAIL wrap4 got=%0d/%0d exp=1/1", rc3, tc3);
    end
    total++;
    if (rc0 !== 16'd17 || tc0 !== 16'd17) begin
      bad++;
      $display("FAIL wrap16 got=%0d/%0d exp=17/17", rc0, tc0);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    rx_data = 8'h00;
    present = 1'b0;
    full = 1'b0;
    tick(1);
    test_reset();
    test_single();
    test_crlf();
    test_backpressure();
    test_case_fold();
    test_enable_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
